// File: rtl/aes_fifo.sv
// aes_fifo: 64-bit nibble-substitution cipher feeding a ciphertext FIFO whose head is decrypted (first-word-fall-through).
// Define AES_FIFO_STATUS_EN to expose full/empty/level status outputs.
module aes_fifo #(
  parameter int DEPTH   = 16,
  parameter int NROUNDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data,
  input  logic [63:0] key,
  input  logic        we,
  input  logic        re,
  input  logic [63:0] expected,
  output logic [63:0] encrypt_data,
  output logic [63:0] decrypt_data,
  output logic        match_result
`ifdef AES_FIFO_STATUS_EN
  ,
  output logic        full,
  output logic        empty,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  function automatic logic [3:0] sbox4(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
      4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
      4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
      4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;  4'hF: r = 4'h2;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'h5;  4'h1: r = 4'hE;  4'h2: r = 4'hF;  4'h3: r = 4'h8;
      4'h4: r = 4'hC;  4'h5: r = 4'h1;  4'h6: r = 4'h2;  4'h7: r = 4'hD;
      4'h8: r = 4'hB;  4'h9: r = 4'h4;  4'hA: r = 4'h6;  4'hB: r = 4'h3;
      4'hC: r = 4'h0;  4'hD: r = 4'h7;  4'hE: r = 4'h9;  4'hF: r = 4'hA;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] sub64(input logic [63:0] s, input logic inv);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 16; i++) begin
      if (inv) r[4*i +: 4] = inv_sbox4(s[4*i +: 4]);
      else     r[4*i +: 4] = sbox4(s[4*i +: 4]);
    end
    return r;
  endfunction

  // Rotation by a multiple of 64 is the identity, so round key r=8 equals the key.
  function automatic logic [63:0] round_key(input logic [63:0] k, input int r);
    logic [63:0] res;
    int m;
    m = (8 * r) % 64;
    if (m == 0) res = k;
    else        res = (k << m) | (k >> (64 - m));
    return res;
  endfunction

  function automatic logic [63:0] encrypt64(input logic [63:0] p, input logic [63:0] k);
    logic [63:0] s;
    s = p;
    for (int r = 1; r <= NROUNDS; r++) begin
      s = sub64(s ^ round_key(k, r - 1), 1'b0);
      s = {s[50:0], s[63:51]};
    end
    return s ^ round_key(k, NROUNDS);
  endfunction

  function automatic logic [63:0] decrypt64(input logic [63:0] c, input logic [63:0] k);
    logic [63:0] s;
    s = c ^ round_key(k, NROUNDS);
    for (int r = NROUNDS; r >= 1; r--) begin
      s = {s[12:0], s[63:13]};
      s = sub64(s, 1'b1) ^ round_key(k, r - 1);
    end
    return s;
  endfunction

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [63:0]       mem_q [DEPTH];
  logic [63:0]       enc_s;
  logic              full_s, empty_s, do_write_s, do_read_s;

  // Full/empty gating decides which requests actually take effect this edge.
  always_comb begin
    enc_s      = encrypt64(data, key);
    full_s     = (count_q == FULL_CNT);
    empty_s    = (count_q == {CNT_W{1'b0}});
    do_write_s = we && !full_s;
    do_read_s  = re && !empty_s;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_write_s) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    else            wr_ptr_d = wr_ptr_q;
    if (do_read_s)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    else            rd_ptr_d = rd_ptr_q;
    case ({do_write_s, do_read_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {ADDR_W{1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_write_s) mem_q[wr_ptr_q] <= enc_s;
  end

  always_comb begin
    encrypt_data = enc_s;
    if (empty_s) decrypt_data = 64'h0;
    else         decrypt_data = decrypt64(mem_q[rd_ptr_q], key);
    match_result = (decrypt_data == expected);
  end

`ifdef AES_FIFO_STATUS_EN
  assign full  = full_s;
  assign empty = empty_s;
  assign level = count_q;
`endif

endmodule

// File: tb/tb_aes_fifo.sv
// Randomised self-checking bench for aes_fifo: plaintext-queue reference model plus directed boundary cases.
module tb_aes_fifo;
  localparam int DEPTH = 16;
  localparam int NR    = 4;
  localparam logic [63:0] SBOX_TAB = 64'h2174_8FE3_DA09_B65C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data = 64'h0, key = 64'h0, expected = 64'h0;
  logic        we = 1'b0, re = 1'b0;
  logic [63:0] encrypt_data, decrypt_data;
  logic        match_result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] model_q[$];
  logic [63:0] pk[DEPTH+2];

  aes_fifo #(.DEPTH(DEPTH), .NROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .data(data), .key(key), .we(we), .re(re),
    .encrypt_data(encrypt_data), .decrypt_data(decrypt_data),
    .expected(expected), .match_result(match_result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] m_enc(input logic [63:0] p, input logic [63:0] k);
    logic [63:0]  s, tab;
    logic [127:0] w;
    tab = SBOX_TAB;
    s = p;
    for (int r = 0; r < NR; r++) begin
      w = {k, k} << (8 * r);
      s = s ^ w[127:64];
      for (int i = 0; i < 16; i++) s[4*i +: 4] = tab[4*s[4*i +: 4] +: 4];
      w = {s, s} << 13;
      s = w[127:64];
    end
    w = {k, k} << (8 * NR);
    return s ^ w[127:64];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    data = d;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [63:0] pt);
    expected = pt;
    #1;
    check(nm, decrypt_data, pt);
    check({nm, "_match"}, {63'h0, match_result}, 64'h1);
    re = 1'b1;
    tick();
    re = 1'b0;
  endtask

  // Reference: queue of accepted plaintexts, updated from pre-edge inputs.
  always @(posedge clk) begin
    bit can_rd, can_wr;
    if (!rst) begin
      can_rd = re && (model_q.size() > 0);
      can_wr = we && (model_q.size() < DEPTH);
      if (can_rd) void'(model_q.pop_front());
      if (can_wr) model_q.push_back(data);
    end
  end

  always @(posedge rst) model_q.delete();

  always @(negedge clk) begin
    logic [63:0] hd;
    hd = (model_q.size() > 0) ? model_q[0] : 64'h0;
    check("encrypt_data", encrypt_data, m_enc(data, key));
    check("decrypt_data", decrypt_data, hd);
    check("match_result", {63'h0, match_result}, {63'h0, (hd == expected)});
  end

  initial begin
    logic [63:0] a, b, c, d, x;
    repeat (2) @(posedge clk);
    #1;
    check("reset_decrypt", decrypt_data, 64'h0);
    check("reset_match", {63'h0, match_result}, 64'h1);
    rst = 1'b0;

    // Zero key/data vector.
    #1;
    check("enc_zero", encrypt_data, 64'h2222_2222_2222_2222);
    check("model_enc_zero", m_enc(64'h0, 64'h0), 64'h2222_2222_2222_2222);
    push(64'h0);
    #1;
    check("zero_roundtrip", decrypt_data, 64'h0);
    check("zero_match", {63'h0, match_result}, 64'h1);
    re = 1'b1;
    tick();
    re = 1'b0;

    // Ten pulsed writes, idle, ten reads.
    key = rand64();
    for (int i = 0; i < 10; i++) begin
      pk[i] = rand64();
      push(pk[i]);
      tick();
    end
    repeat (5) tick();
    for (int i = 0; i < 10; i++) pop_chk("ten_pop", pk[i]);

    // Overfill by two, then drain past empty.
    we = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      pk[i] = rand64();
      data = pk[i];
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < DEPTH; i++) pop_chk("full_pop", pk[i]);
    re = 1'b1;
    tick();
    re = 1'b0;
    #1;
    check("overdrain_zero", decrypt_data, 64'h0);

    // Read on empty, then simultaneous we/re with three entries.
    re = 1'b1;
    tick();
    re = 1'b0;
    #1;
    check("empty_read_zero", decrypt_data, 64'h0);
    a = rand64(); b = rand64(); c = rand64(); d = rand64();
    push(a); push(b); push(c);
    data = d; we = 1'b1; re = 1'b1;
    #1;
    check("wr_rd_head_before", decrypt_data, a);
    tick();
    we = 1'b0; re = 1'b0;
    #1;
    check("wr_rd_head_after", decrypt_data, b);
    pop_chk("wr_rd_pop_b", b);
    pop_chk("wr_rd_pop_c", c);
    pop_chk("wr_rd_pop_d", d);
    #1;
    check("wr_rd_empty", decrypt_data, 64'h0);

    // Asynchronous reset between edges with five entries queued.
    for (int i = 0; i < 5; i++) push(rand64());
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_zero", decrypt_data, 64'h0);
    tick();
    rst = 1'b0;
    x = rand64();
    push(x);
    pop_chk("post_rst_roundtrip", x);
    #1;
    check("post_rst_empty", decrypt_data, 64'h0);

    // Mismatch detection.
    x = rand64();
    push(x);
    expected = x ^ 64'h1;
    #1;
    check("mismatch_flag", {63'h0, match_result}, 64'h0);
    re = 1'b1;
    tick();
    re = 1'b0;

    // Random traffic, write-heavy then read-heavy, fixed key while entries are queued.
    key = rand64();
    for (int n = 0; n < 600; n++) begin
      if (n < 300) begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 2) == 0);
      end else begin
        we = ($urandom_range(0, 2) == 0);
        re = ($urandom_range(0, 3) != 0);
      end
      data = rand64();
      if ($urandom_range(0, 3) == 0) expected = rand64();
      else expected = (model_q.size() > 0) ? model_q[0] : 64'h0;
      tick();
    end
    we = 1'b0;
    re = 1'b1;
    repeat (DEPTH + 1) tick();
    re = 1'b0;
    #1;
    check("final_empty", decrypt_data, 64'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_fifo.md
Name: aes_fifo

Overview:
- 64-bit block-cipher engine with an internal ciphertext FIFO.
- On write, the plaintext is encrypted with the 64-bit key and the ciphertext is queued.
- On read, the FIFO head is decrypted with the current key and presented, so the original plaintext comes back in write order.
- A built-in equality comparator provides the scoreboard check for verification.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two and at least 10.
- NROUNDS, 4, cipher rounds; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- data  in  64  plaintext to encrypt and enqueue
- key  in  64  cipher key, used by both encrypt and decrypt
- we  in  1  write enable
- re  in  1  read enable
- encrypt_data  out  64  ciphertext of data under key
- decrypt_data  out  64  plaintext decrypted from the FIFO head
- expected  in  64  reference plaintext for comparison
- match_result  out  1  1 when decrypt_data == expected

Behaviour:
Cipher:
- Shared definitions:
  - rotl(x,n) is a 64-bit rotate-left.
  - Round key k_r = rotl(key, 8*r), for r = 0..NROUNDS.
  - SBOX is a nibble substitution. Input 0..F maps to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - INV_SBOX is the exact inverse of SBOX.
- Encrypt E(p): s = p. For r = 1..NROUNDS:
  - s ^= k_(r-1)
  - apply SBOX to all 16 nibbles
  - s = rotl(s,13), i.e. {s[50:0], s[63:51]}
  - After the last round: s ^= k_NROUNDS.
- Decrypt D(c): s = c ^ k_NROUNDS. For r = NROUNDS down to 1:
  - s = rotate-right(s,13)
  - apply INV_SBOX to all nibbles
  - s ^= k_(r-1)
- D(E(p)) == p is required for all p and key.
- Both E and D are purely combinational; no pipeline latency.

Outputs:
- encrypt_data = E(data) continuously. No register; valid in the same cycle data/key are applied.
- decrypt_data = D(mem[rd_ptr]) when the FIFO is not empty, otherwise 64'h0. This is first-word-fall-through: the head is visible before the read edge.
- match_result = (decrypt_data == expected), combinational.

FIFO:
- Stores ciphertext only. Decryption always uses the current key input.
- Write: at a rising edge with we=1 and not full, mem[wr_ptr] <= E(data); wr_ptr++ and count++.
- Read: at a rising edge with re=1 and not empty, rd_ptr++ and count--. The value consumed is the decrypt_data shown before that edge.
- Both pointers wrap modulo DEPTH. count is ADDR_W+1 bits wide.
- we while full: write ignored, no state change.
- re while empty: read ignored, no state change.
- we and re in the same cycle, FIFO neither empty nor full: both occur, count unchanged.
- we and re when full: only the read occurs.
- we and re when empty: only the write occurs. The new entry becomes visible after the edge.

Reset:
- rst asserted asynchronously clears rd_ptr, wr_ptr and count.
- decrypt_data therefore reads 0 immediately.
- Memory contents are not cleared.
- encrypt_data and match_result stay combinational and are unaffected by rst.
- Reset in the middle of a transfer discards all queued entries.

Optional Feature:
- Macro AES_FIFO_STATUS_EN.
- When defined, the block adds these outputs:
  - full (1 bit): count == DEPTH
  - empty (1 bit): count == 0
  - level (ADDR_W+1 bits): equals count
- All three are combinational from the registered count, with reset values full=0, empty=1, level=0.
- When not defined, these ports do not exist. Internal full/empty gating still applies.

Test Plan:
- key=0, data=0 -> encrypt_data = 64'h2222222222222222. Write once, then decrypt_data = 0; with expected=0, match_result=1.
- Random key; write 10 random packets with one-cycle we pulses, then wait 5 cycles. Pop 10 with re pulses, sampling decrypt_data before each read edge -> all 10 equal the originals in order, match_result=1 each time.
- Write DEPTH+2 packets -> the last 2 are dropped. Reading DEPTH entries returns the first DEPTH plaintexts; a further re leaves pointers unchanged and decrypt_data=0.
- Read on an empty FIFO -> no state change, decrypt_data=0. A simultaneous we/re with 3 entries queued leaves count at 3, and the head advances by one.
- Assert rst asynchronously mid-stream, between clock edges, with 5 entries queued -> decrypt_data goes to 0 immediately. A subsequent write/read round-trips correctly.
- Set expected to the original plaintext XOR 1 -> match_result=0.
